// File: rtl/multi_issue_decode_stage_pkg.sv
// Shared widths, MIPS opcodes, control-bit positions and FSM states for the decode stage.
package multi_issue_decode_stage_pkg;

  localparam int IWIDTH       = 32;
  localparam int DWIDTH       = 32;
  localparam int AWIDTH       = 5;
  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;
  localparam int IMM_WIDTH    = 16;
  localparam int JUMP_WIDTH   = 26;
  localparam int CTRL_WIDTH   = 8;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;
  localparam logic [FUNCT_WIDTH-1:0]  FN_JR    = 6'h08;

  // Bit positions inside each lane's 8-bit control byte
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_REG_DST   = 3;
  localparam int CTRL_ALU_SRC   = 4;
  localparam int CTRL_BRANCH    = 5;
  localparam int CTRL_JAL       = 6;
  localparam int CTRL_JR        = 7;

  typedef enum logic {
    ST_ISSUE  = 1'b0,
    ST_REPLAY = 1'b1
  } state_e;

  // rt is only read as an operand by R-type, branch and store instructions
  function automatic logic uses_rt(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multi_issue_decode_stage_decoder.sv
// Single-lane MIPS instruction decoder: field extraction and control byte.
module multi_issue_decode_stage_decoder
  import multi_issue_decode_stage_pkg::*;
(
  input  logic [IWIDTH-1:0]       instr_i,
  output logic [OPCODE_WIDTH-1:0] opcode_o,
  output logic [FUNCT_WIDTH-1:0]  funct_o,
  output logic [IMM_WIDTH-1:0]    imm_o,
  output logic [JUMP_WIDTH-1:0]   jal_addr_o,
  output logic [AWIDTH-1:0]       rs_o,
  output logic [AWIDTH-1:0]       rt_o,
  output logic [AWIDTH-1:0]       rd_o,
  output logic [CTRL_WIDTH-1:0]   ctrl_o
);

  assign opcode_o   = instr_i[31:26];
  assign rs_o       = instr_i[25:21];
  assign rt_o       = instr_i[20:16];
  assign rd_o       = instr_i[15:11];
  assign funct_o    = instr_i[5:0];
  assign imm_o      = instr_i[15:0];
  assign jal_addr_o = instr_i[25:0];

  // Control byte from opcode (and funct for jr)
  always_comb begin
    ctrl_o = '0;
    case (opcode_o)
      OP_RTYPE: begin
        if (funct_o == FN_JR) begin
          ctrl_o[CTRL_JR] = 1'b1;
        end else begin
          ctrl_o[CTRL_REG_DST]   = 1'b1;
          ctrl_o[CTRL_REG_WRITE] = 1'b1;
        end
      end
      OP_LW: begin
        ctrl_o[CTRL_ALU_SRC]   = 1'b1;
        ctrl_o[CTRL_MEMTOREG]  = 1'b1;
        ctrl_o[CTRL_REG_WRITE] = 1'b1;
      end
      OP_SW: begin
        ctrl_o[CTRL_ALU_SRC]  = 1'b1;
        ctrl_o[CTRL_MEMWRITE] = 1'b1;
      end
      OP_BEQ, OP_BNE: ctrl_o[CTRL_BRANCH] = 1'b1;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        ctrl_o[CTRL_ALU_SRC]   = 1'b1;
        ctrl_o[CTRL_REG_WRITE] = 1'b1;
      end
      OP_JAL: begin
        ctrl_o[CTRL_JAL]       = 1'b1;
        ctrl_o[CTRL_REG_WRITE] = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multi_issue_decode_stage_regfile.sv
// Multi-ported register file: 2*LANES read ports with same-cycle writeback bypass, LANES write ports.
module regfile_mp #(
  parameter int LANES  = 2,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [2*LANES*AWIDTH-1:0]   raddr_i,
  output logic [2*LANES*DWIDTH-1:0]   rdata_o,
  input  logic [LANES-1:0]            we_i,
  input  logic [LANES*AWIDTH-1:0]     waddr_i,
  input  logic [LANES*DWIDTH-1:0]     wdata_i
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];

  // Write ports; later lanes overwrite earlier ones so the highest lane wins, r0 is never written
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 2**AWIDTH; r++) mem_q[r] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (we_i[l] && (waddr_i[l*AWIDTH +: AWIDTH] != '0))
          mem_q[waddr_i[l*AWIDTH +: AWIDTH]] <= wdata_i[l*DWIDTH +: DWIDTH];
      end
    end
  end

  // Read ports with bypass from the writes of this cycle, highest lane wins
  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < 2*LANES; p++) begin
      rdata_o[p*DWIDTH +: DWIDTH] = mem_q[raddr_i[p*AWIDTH +: AWIDTH]];
      for (int l = 0; l < LANES; l++) begin
        if (we_i[l] && (waddr_i[l*AWIDTH +: AWIDTH] == raddr_i[p*AWIDTH +: AWIDTH]))
          rdata_o[p*DWIDTH +: DWIDTH] = wdata_i[l*DWIDTH +: DWIDTH];
      end
      if (raddr_i[p*AWIDTH +: AWIDTH] == '0) rdata_o[p*DWIDTH +: DWIDTH] = '0;
    end
  end

endmodule

// File: rtl/multi_issue_decode_stage.sv
// N-lane decode stage: per-lane decode, operand read, intra-bundle RAW split and ID/EX register.
//   state     | meaning
//   ST_ISSUE  | accepting new bundles from fetch
//   ST_REPLAY | issuing the held remainder of a split bundle
module multi_issue_decode_stage
  import multi_issue_decode_stage_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                        md_i_clk,
  input  logic                        md_i_rst,
  input  logic                        md_i_valid,
  output logic                        md_o_ready,
  input  logic [LANES*IWIDTH-1:0]     md_i_instr,
  input  logic [LANES-1:0]            md_i_lane_vld,
  input  logic                        md_i_flush,
  input  logic [LANES-1:0]            md_i_wb_en,
  input  logic [LANES*AWIDTH-1:0]     md_i_wb_addr,
  input  logic [LANES*DWIDTH-1:0]     md_i_wb_data,
  output logic                        md_o_valid,
  input  logic                        md_i_ready,
  output logic [LANES-1:0]            md_o_lane_vld,
  output logic [LANES*8-1:0]          md_o_ctrl,
  output logic [LANES*6-1:0]          md_o_opcode,
  output logic [LANES*6-1:0]          md_o_funct,
  output logic [LANES*16-1:0]         md_o_imm,
  output logic [LANES*26-1:0]         md_o_jal_addr,
  output logic [LANES*AWIDTH-1:0]     md_o_addr_rs,
  output logic [LANES*AWIDTH-1:0]     md_o_addr_rt,
  output logic [LANES*AWIDTH-1:0]     md_o_addr_rd,
  output logic [LANES*DWIDTH-1:0]     md_o_data_rs,
  output logic [LANES*DWIDTH-1:0]     md_o_data_rt,
  output logic                        md_o_split
);

  state_e                    state_q, state_d;
  logic [LANES*IWIDTH-1:0]   hold_instr_q, hold_instr_d;
  logic [LANES-1:0]          hold_rem_q, hold_rem_d;
  logic                      valid_q, valid_d, split_q, split_d;
  logic [LANES-1:0]          lane_vld_q, lane_vld_d;
  logic [LANES*8-1:0]        ctrl_q, ctrl_d;
  logic [LANES*6-1:0]        opcode_q, opcode_d, funct_q, funct_d;
  logic [LANES*16-1:0]       imm_q, imm_d;
  logic [LANES*26-1:0]       jal_q, jal_d;
  logic [LANES*AWIDTH-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [LANES*DWIDTH-1:0]   drs_q, drs_d, drt_q, drt_d;

  logic [LANES*IWIDTH-1:0]   cur_instr;
  logic [LANES-1:0]          cur_vld;
  logic [LANES*8-1:0]        dec_ctrl;
  logic [LANES*6-1:0]        dec_opcode, dec_funct;
  logic [LANES*16-1:0]       dec_imm;
  logic [LANES*26-1:0]       dec_jal;
  logic [LANES*AWIDTH-1:0]   dec_rs, dec_rt, dec_rd;
  logic [2*LANES*AWIDTH-1:0] rf_raddr;
  logic [2*LANES*DWIDTH-1:0] rf_rdata;
  logic [LANES*DWIDTH-1:0]   rs_data, rt_data;
  logic [AWIDTH-1:0]         dest [LANES];
  logic [LANES-1:0]          live, dep, issue_mask, rem_mask;
  logic                      blocked, hazard, load;

  assign cur_instr = (state_q == ST_REPLAY) ? hold_instr_q : md_i_instr;
  assign cur_vld   = (state_q == ST_REPLAY) ? hold_rem_q   : md_i_lane_vld;
  assign load      = !valid_q || md_i_ready;
  assign md_o_ready = (state_q == ST_ISSUE) && load;

  for (genvar l = 0; l < LANES; l++) begin : g_dec
    multi_issue_decode_stage_decoder u_dec (
      .instr_i    (cur_instr[l*IWIDTH +: IWIDTH]),
      .opcode_o   (dec_opcode[l*6 +: 6]),
      .funct_o    (dec_funct[l*6 +: 6]),
      .imm_o      (dec_imm[l*16 +: 16]),
      .jal_addr_o (dec_jal[l*26 +: 26]),
      .rs_o       (dec_rs[l*AWIDTH +: AWIDTH]),
      .rt_o       (dec_rt[l*AWIDTH +: AWIDTH]),
      .rd_o       (dec_rd[l*AWIDTH +: AWIDTH]),
      .ctrl_o     (dec_ctrl[l*8 +: 8])
    );
  end

  // Port 2l reads rs of lane l, port 2l+1 reads rt of lane l
  always_comb begin
    rf_raddr = '0;
    rs_data  = '0;
    rt_data  = '0;
    for (int l = 0; l < LANES; l++) begin
      rf_raddr[(2*l)*AWIDTH +: AWIDTH]   = dec_rs[l*AWIDTH +: AWIDTH];
      rf_raddr[(2*l+1)*AWIDTH +: AWIDTH] = dec_rt[l*AWIDTH +: AWIDTH];
      rs_data[l*DWIDTH +: DWIDTH] = rf_rdata[(2*l)*DWIDTH +: DWIDTH];
      rt_data[l*DWIDTH +: DWIDTH] = rf_rdata[(2*l+1)*DWIDTH +: DWIDTH];
    end
  end

  regfile_mp #(.LANES(LANES), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_rf (
    .clk_i   (md_i_clk),
    .rst_ni  (md_i_rst),
    .raddr_i (rf_raddr),
    .rdata_o (rf_rdata),
    .we_i    (md_i_wb_en),
    .waddr_i (md_i_wb_addr),
    .wdata_i (md_i_wb_data)
  );

  // Live destinations, dependent lanes, and the split point at the lowest dependent lane
  always_comb begin
    dest       = '{default: '0};
    live       = '0;
    dep        = '0;
    issue_mask = '0;
    blocked    = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if (dec_ctrl[j*8 + CTRL_JAL])          dest[j] = AWIDTH'(31);
      else if (dec_ctrl[j*8 + CTRL_REG_DST]) dest[j] = dec_rd[j*AWIDTH +: AWIDTH];
      else                                   dest[j] = dec_rt[j*AWIDTH +: AWIDTH];
      live[j] = cur_vld[j] && dec_ctrl[j*8 + CTRL_REG_WRITE] && (dest[j] != '0);
    end
    for (int j = 1; j < LANES; j++) begin
      for (int i = 0; i < j; i++) begin
        if (cur_vld[j] && live[i] &&
            ((dec_rs[j*AWIDTH +: AWIDTH] == dest[i]) ||
             (uses_rt(dec_opcode[j*6 +: 6]) && (dec_rt[j*AWIDTH +: AWIDTH] == dest[i]))))
          dep[j] = 1'b1;
      end
    end
    for (int j = 0; j < LANES; j++) begin
      if (dep[j]) blocked = 1'b1;
      if (!blocked) issue_mask[j] = cur_vld[j];
    end
    rem_mask = cur_vld & ~issue_mask;
    hazard   = |dep;
  end

  // Next state, hold buffer and ID/EX register contents; flush overrides everything
  always_comb begin
    state_d = state_q;  hold_instr_d = hold_instr_q;  hold_rem_d = hold_rem_q;
    valid_d = valid_q;  split_d = split_q;  lane_vld_d = lane_vld_q;
    ctrl_d = ctrl_q;  opcode_d = opcode_q;  funct_d = funct_q;  imm_d = imm_q;  jal_d = jal_q;
    rs_d = rs_q;  rt_d = rt_q;  rd_d = rd_q;  drs_d = drs_q;  drt_d = drt_q;
    if (load && ((state_q == ST_REPLAY) || md_i_valid)) begin
      valid_d = 1'b1;  split_d = hazard;  lane_vld_d = issue_mask;
      ctrl_d = dec_ctrl;  opcode_d = dec_opcode;  funct_d = dec_funct;  imm_d = dec_imm;
      jal_d = dec_jal;  rs_d = dec_rs;  rt_d = dec_rt;  rd_d = dec_rd;
      drs_d = rs_data;  drt_d = rt_data;
      hold_rem_d = rem_mask;
      if (state_q == ST_ISSUE) hold_instr_d = md_i_instr;
      state_d = hazard ? ST_REPLAY : ST_ISSUE;
    end else if (load) begin
      valid_d = 1'b0;  split_d = 1'b0;  lane_vld_d = '0;
    end
    if (md_i_flush) begin
      valid_d = 1'b0;  split_d = 1'b0;  lane_vld_d = '0;
      hold_instr_d = '0;  hold_rem_d = '0;  state_d = ST_ISSUE;
    end
  end

  // State, hold buffer and ID/EX pipeline register
  always_ff @(posedge md_i_clk or negedge md_i_rst) begin
    if (!md_i_rst) begin
      state_q <= ST_ISSUE;  hold_instr_q <= '0;  hold_rem_q <= '0;
      valid_q <= 1'b0;  split_q <= 1'b0;  lane_vld_q <= '0;
      ctrl_q <= '0;  opcode_q <= '0;  funct_q <= '0;  imm_q <= '0;  jal_q <= '0;
      rs_q <= '0;  rt_q <= '0;  rd_q <= '0;  drs_q <= '0;  drt_q <= '0;
    end else begin
      state_q <= state_d;  hold_instr_q <= hold_instr_d;  hold_rem_q <= hold_rem_d;
      valid_q <= valid_d;  split_q <= split_d;  lane_vld_q <= lane_vld_d;
      ctrl_q <= ctrl_d;  opcode_q <= opcode_d;  funct_q <= funct_d;  imm_q <= imm_d;  jal_q <= jal_d;
      rs_q <= rs_d;  rt_q <= rt_d;  rd_q <= rd_d;  drs_q <= drs_d;  drt_q <= drt_d;
    end
  end

  assign md_o_valid    = valid_q;
  assign md_o_split    = split_q;
  assign md_o_lane_vld = lane_vld_q;
  assign md_o_ctrl     = ctrl_q;
  assign md_o_opcode   = opcode_q;
  assign md_o_funct    = funct_q;
  assign md_o_imm      = imm_q;
  assign md_o_jal_addr = jal_q;
  assign md_o_addr_rs  = rs_q;
  assign md_o_addr_rt  = rt_q;
  assign md_o_addr_rd  = rd_q;
  assign md_o_data_rs  = drs_q;
  assign md_o_data_rt  = drt_q;

endmodule

// File: tb/tb_multi_issue_decode_stage.sv
// Directed bench for the 2-lane decode stage with hand-computed expectations.
module tb_multi_issue_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready_o, flush, ds_ready, out_valid, split;
  logic [63:0] instr;
  logic [1:0]  lane_vld, wb_en, o_lane_vld;
  logic [9:0]  wb_addr, a_rs, a_rt, a_rd;
  logic [63:0] wb_data, d_rs, d_rt;
  logic [15:0] ctrl;
  logic [11:0] opcode, funct;
  logic [31:0] imm;
  logic [51:0] jal_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multi_issue_decode_stage dut (
    .md_i_clk(clk), .md_i_rst(rst_n), .md_i_valid(in_valid), .md_o_ready(out_ready_o),
    .md_i_instr(instr), .md_i_lane_vld(lane_vld), .md_i_flush(flush),
    .md_i_wb_en(wb_en), .md_i_wb_addr(wb_addr), .md_i_wb_data(wb_data),
    .md_o_valid(out_valid), .md_i_ready(ds_ready), .md_o_lane_vld(o_lane_vld),
    .md_o_ctrl(ctrl), .md_o_opcode(opcode), .md_o_funct(funct), .md_o_imm(imm),
    .md_o_jal_addr(jal_addr), .md_o_addr_rs(a_rs), .md_o_addr_rt(a_rt), .md_o_addr_rd(a_rd),
    .md_o_data_rs(d_rs), .md_o_data_rt(d_rt), .md_o_split(split)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] add_3_1_2, sub_4_2_1, or_5_3_1;

  initial begin
    add_3_1_2 = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    sub_4_2_1 = rtype(5'd2, 5'd1, 5'd4, 6'h22);
    or_5_3_1  = rtype(5'd3, 5'd1, 5'd5, 6'h25);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; ds_ready = 1'b1;
    instr = '0; lane_vld = '0; wb_en = '0; wb_addr = '0; wb_data = '0;

    // Reset
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_lane_vld", o_lane_vld, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_data_rs", d_rs, 0);
    chk("rst_split", split, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", out_ready_o, 1);

    // Load r1=10, r2=20, then independent bundle
    wb_en = 2'b11; wb_addr = {5'd2, 5'd1}; wb_data = {32'd20, 32'd10};
    tick();
    wb_en = 2'b00; in_valid = 1'b1; instr = {sub_4_2_1, add_3_1_2}; lane_vld = 2'b11;
    tick();
    chk("ind_valid", out_valid, 1);
    chk("ind_lane_vld", o_lane_vld, 2'b11);
    chk("ind_data_rs", d_rs, {32'd20, 32'd10});
    chk("ind_data_rt", d_rt, {32'd10, 32'd20});
    chk("ind_split", split, 0);
    chk("ind_ctrl", ctrl, 16'h0909);
    chk("ind_addr_rd", a_rd, {5'd4, 5'd3});

    // RAW split
    instr = {or_5_3_1, add_3_1_2};
    #1;
    chk("raw_ready_pre", out_ready_o, 1);
    tick();
    in_valid = 1'b0;
    chk("raw1_lane_vld", o_lane_vld, 2'b01);
    chk("raw1_split", split, 1);
    chk("raw1_ready", out_ready_o, 0);
    tick();
    chk("raw2_lane_vld", o_lane_vld, 2'b10);
    chk("raw2_split", split, 0);
    chk("raw2_addr_rs", a_rs, {5'd3, 5'd1});
    chk("raw2_addr_rd_hi", a_rd[9:5], 5'd5);
    tick();
    chk("raw3_ready", out_ready_o, 1);
    chk("raw3_valid", out_valid, 0);

    // Bypass with write priority: add r8,r7,r0 with two writes to r7
    in_valid = 1'b1; lane_vld = 2'b01;
    instr = {32'h0, rtype(5'd7, 5'd0, 5'd8, 6'h20)};
    wb_en = 2'b11; wb_addr = {5'd7, 5'd7}; wb_data = {32'hBB, 32'hAA};
    tick();
    chk("byp_data_rs", d_rs[31:0], 32'hBB);
    chk("byp_data_rt", d_rt[31:0], 32'h0);
    wb_en = 2'b00;
    tick();
    chk("file_r7", d_rs[31:0], 32'hBB);
    instr = {32'h0, rtype(5'd0, 5'd7, 5'd8, 6'h20)};
    wb_en = 2'b01; wb_addr = {5'd0, 5'd0}; wb_data = {32'h0, 32'h55};
    tick();
    chk("r0_byp", d_rs[31:0], 32'h0);
    chk("r0_rt_r7", d_rt[31:0], 32'hBB);
    wb_en = 2'b00;
    tick();
    chk("r0_file", d_rs[31:0], 32'h0);

    // Backpressure
    ds_ready = 1'b0; instr = {sub_4_2_1, add_3_1_2}; lane_vld = 2'b11;
    #1;
    chk("bp_ready0", out_ready_o, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_lane_vld", o_lane_vld, 2'b01);
      chk("bp_data_rt", d_rt[31:0], 32'hBB);
      chk("bp_ready", out_ready_o, 0);
    end
    ds_ready = 1'b1;
    #1;
    chk("bp_ready_back", out_ready_o, 1);
    tick();
    chk("bp_new_lane_vld", o_lane_vld, 2'b11);
    chk("bp_new_data_rs", d_rs, {32'd20, 32'd10});

    // Flush during REPLAY
    instr = {or_5_3_1, add_3_1_2};
    tick();
    chk("fl_split", split, 1);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_split_clr", split, 0);
    chk("fl_ready", out_ready_o, 1);
    flush = 1'b0;
    tick();
    chk("fl_no_held", out_valid, 0);
    chk("fl_lane_vld", o_lane_vld, 0);
    in_valid = 1'b1; flush = 1'b1; instr = {sub_4_2_1, add_3_1_2};
    tick();
    chk("fl_beats_accept", out_valid, 0);
    flush = 1'b0;

    // rt is a destination for addi (no hazard) but a source for sw (hazard)
    instr = {itype(6'h08, 5'd1, 5'd3, 16'd7), add_3_1_2};
    tick();
    chk("addi_lane_vld", o_lane_vld, 2'b11);
    chk("addi_split", split, 0);
    instr = {itype(6'h2B, 5'd1, 5'd3, 16'd4), add_3_1_2};
    tick();
    in_valid = 1'b0;
    chk("sw_lane_vld", o_lane_vld, 2'b01);
    chk("sw_split", split, 1);
    tick();
    chk("sw2_lane_vld", o_lane_vld, 2'b10);
    chk("sw2_ctrl", ctrl[15:8], 8'h14);
    chk("sw2_imm", imm[31:16], 16'd4);
    tick();

    // Reset mid-REPLAY after r5 was written
    wb_en = 2'b01; wb_addr = {5'd0, 5'd5}; wb_data = {32'h0, 32'd55};
    tick();
    wb_en = 2'b00; in_valid = 1'b1; instr = {or_5_3_1, add_3_1_2};
    tick();
    chk("mr_split", split, 1);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_lane_vld", o_lane_vld, 0);
    chk("mr_ctrl", ctrl, 0);
    chk("mr_data_rs", d_rs, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_ready", out_ready_o, 1);
    in_valid = 1'b1; lane_vld = 2'b01; instr = {32'h0, rtype(5'd5, 5'd5, 5'd6, 6'h20)};
    tick();
    in_valid = 1'b0;
    chk("mr_r5_valid", out_valid, 1);
    chk("mr_r5_zero", d_rs[31:0], 32'h0);
    tick();
    chk("mr_held_lost", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
